// File: rtl/vc_trace_val_rdy_monitor.sv
// Multi-channel val/rdy trace monitor: registered per-channel trace codes,
// saturating transfer/stall counters and sticky protocol-violation flags.
module vc_trace_val_rdy_monitor #(
  parameter int NUM_CHANNELS = 2,
  parameter int NUMBITS      = 8,
  parameter int CNT_WIDTH    = 4,
  parameter int MUTEX_CHECK  = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              en,
  input  logic [NUM_CHANNELS-1:0]           val,
  input  logic [NUM_CHANNELS-1:0]           rdy,
  input  logic [NUM_CHANNELS*NUMBITS-1:0]   msg,
  output logic [2*NUM_CHANNELS-1:0]         code,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] xfer_cnt,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] stall_cnt,
  output logic [NUM_CHANNELS-1:0]           viol_drop,
  output logic [NUM_CHANNELS-1:0]           viol_chg,
  output logic                              mutex_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

  function automatic logic [3:0] popcount(input logic [NUM_CHANNELS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  logic [2*NUM_CHANNELS-1:0]         code_r,  code_s;
  logic [NUM_CHANNELS*CNT_WIDTH-1:0] xfer_r,  xfer_s;
  logic [NUM_CHANNELS*CNT_WIDTH-1:0] stall_r, stall_s;
  logic [NUM_CHANNELS-1:0]           drop_r,  drop_s;
  logic [NUM_CHANNELS-1:0]           chg_r,   chg_s;
  logic [NUM_CHANNELS-1:0]           pend_r,  pend_s;
  logic [NUM_CHANNELS*NUMBITS-1:0]   held_r,  held_s;
  logic                              mutex_r, mutex_s;

  // Next-state: trace codes, stall tracking, counters and sticky flags.
  always_comb begin
    code_s  = code_r;
    xfer_s  = xfer_r;
    stall_s = stall_r;
    drop_s  = drop_r;
    chg_s   = chg_r;
    pend_s  = pend_r;
    held_s  = held_r;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      code_s[2*c +: 2] = {val[c], rdy[c]};
      pend_s[c]        = val[c] & ~rdy[c];
      // Capture only on the first stall cycle so held is the promised message.
      if (val[c] & ~rdy[c] & ~pend_r[c]) begin
        held_s[c*NUMBITS +: NUMBITS] = msg[c*NUMBITS +: NUMBITS];
      end else begin
        held_s[c*NUMBITS +: NUMBITS] = held_r[c*NUMBITS +: NUMBITS];
      end
      if (clear) begin
        xfer_s[c*CNT_WIDTH +: CNT_WIDTH]  = {CNT_WIDTH{1'b0}};
        stall_s[c*CNT_WIDTH +: CNT_WIDTH] = {CNT_WIDTH{1'b0}};
        drop_s[c]                         = 1'b0;
        chg_s[c]                          = 1'b0;
      end else begin
        if (en && val[c] && rdy[c] && (xfer_r[c*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)) begin
          xfer_s[c*CNT_WIDTH +: CNT_WIDTH] = xfer_r[c*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
        end else begin
          xfer_s[c*CNT_WIDTH +: CNT_WIDTH] = xfer_r[c*CNT_WIDTH +: CNT_WIDTH];
        end
        if (en && val[c] && !rdy[c] && (stall_r[c*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)) begin
          stall_s[c*CNT_WIDTH +: CNT_WIDTH] = stall_r[c*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
        end else begin
          stall_s[c*CNT_WIDTH +: CNT_WIDTH] = stall_r[c*CNT_WIDTH +: CNT_WIDTH];
        end
        drop_s[c] = drop_r[c] | (pend_r[c] & ~val[c]);
        chg_s[c]  = chg_r[c] | (pend_r[c] & val[c] &
                    (msg[c*NUMBITS +: NUMBITS] != held_r[c*NUMBITS +: NUMBITS]));
      end
    end
    if (MUTEX_CHECK == 32'sd0) begin
      mutex_s = 1'b0;
    end else if (clear) begin
      mutex_s = 1'b0;
    end else if (popcount(val & rdy) > 4'd1) begin
      mutex_s = 1'b1;
    end else begin
      mutex_s = mutex_r;
    end
  end

  // State registers; reset also forgets any stall in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_r  <= '0;
      xfer_r  <= '0;
      stall_r <= '0;
      drop_r  <= '0;
      chg_r   <= '0;
      pend_r  <= '0;
      held_r  <= '0;
      mutex_r <= 1'b0;
    end else begin
      code_r  <= code_s;
      xfer_r  <= xfer_s;
      stall_r <= stall_s;
      drop_r  <= drop_s;
      chg_r   <= chg_s;
      pend_r  <= pend_s;
      held_r  <= held_s;
      mutex_r <= mutex_s;
    end
  end

  assign code      = code_r;
  assign xfer_cnt  = xfer_r;
  assign stall_cnt = stall_r;
  assign viol_drop = drop_r;
  assign viol_chg  = chg_r;
  assign mutex_err = mutex_r;

endmodule

// File: tb/tb_vc_trace_val_rdy_monitor.sv
// Scoreboard bench for vc_trace_val_rdy_monitor: a transaction-level model
// predicts each cycle's outputs; a monitor process compares after each edge.
module tb_vc_trace_val_rdy_monitor;

  localparam int NC = 2;
  localparam int NB = 8;
  localparam int CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n, clear, en;
  logic [NC-1:0]    val, rdy;
  logic [NC*NB-1:0] msg;

  logic [2*NC-1:0]  d0_code,  d1_code;
  logic [NC*CW-1:0] d0_xfer,  d1_xfer, d0_stall, d1_stall;
  logic [NC-1:0]    d0_vd, d1_vd, d0_vc, d1_vc;
  logic             d0_mx, d1_mx;

  vc_trace_val_rdy_monitor #(.NUM_CHANNELS(NC), .NUMBITS(NB), .CNT_WIDTH(CW), .MUTEX_CHECK(0)) d0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .val(val), .rdy(rdy), .msg(msg),
    .code(d0_code), .xfer_cnt(d0_xfer), .stall_cnt(d0_stall), .viol_drop(d0_vd),
    .viol_chg(d0_vc), .mutex_err(d0_mx));

  vc_trace_val_rdy_monitor #(.NUM_CHANNELS(NC), .NUMBITS(NB), .CNT_WIDTH(CW), .MUTEX_CHECK(1)) d1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .val(val), .rdy(rdy), .msg(msg),
    .code(d1_code), .xfer_cnt(d1_xfer), .stall_cnt(d1_stall), .viol_drop(d1_vd),
    .viol_chg(d1_vc), .mutex_err(d1_mx));

  always #5 clk = ~clk;

  typedef struct {
    logic [2*NC-1:0]  code;
    logic [NC*CW-1:0] xfer;
    logic [NC*CW-1:0] stall;
    logic [NC-1:0]    vd;
    logic [NC-1:0]    vc;
    logic             mx;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state, one entry per channel.
  int unsigned m_xfer[NC], m_stall[NC];
  bit          m_pend[NC], m_vd[NC], m_vc[NC], m_mx;
  logic [NB-1:0] m_held[NC];
  logic [1:0]    m_code[NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    int fires;
    logic [NB-1:0] mc;
    fires = 0;
    if (!reset_n) begin
      for (int c = 0; c < NC; c++) begin
        m_xfer[c] = 0; m_stall[c] = 0; m_pend[c] = 0; m_vd[c] = 0; m_vc[c] = 0;
        m_held[c] = '0; m_code[c] = 2'b00;
      end
      m_mx = 0;
      return;
    end
    for (int c = 0; c < NC; c++) begin
      mc = msg[c*NB +: NB];
      m_code[c] = {val[c], rdy[c]};
      if (val[c] && rdy[c]) fires++;
      if (clear) begin
        m_xfer[c] = 0; m_stall[c] = 0; m_vd[c] = 0; m_vc[c] = 0;
      end else begin
        if (en && val[c] && rdy[c] && m_xfer[c] < CMAX) m_xfer[c]++;
        if (en && val[c] && !rdy[c] && m_stall[c] < CMAX) m_stall[c]++;
        if (m_pend[c] && !val[c]) m_vd[c] = 1;
        if (m_pend[c] && val[c] && mc != m_held[c]) m_vc[c] = 1;
      end
      if (val[c] && !rdy[c] && !m_pend[c]) m_held[c] = mc;
      m_pend[c] = val[c] && !rdy[c];
    end
    m_mx = clear ? 1'b0 : (m_mx || fires > 1);
  endfunction

  function automatic void push_exp();
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      e.code[2*c +: 2]   = m_code[c];
      e.xfer[c*CW +: CW]  = CW'(m_xfer[c]);
      e.stall[c*CW +: CW] = CW'(m_stall[c]);
      e.vd[c] = m_vd[c];
      e.vc[c] = m_vc[c];
    end
    e.mx = m_mx;
    q.push_back(e);
  endfunction

  task automatic drive(input logic rn, input logic [NC-1:0] v, input logic [NC-1:0] r,
                       input logic [NC*NB-1:0] m, input logic clr, input logic e);
    @(negedge clk);
    reset_n = rn; val = v; rdy = r; msg = m; clear = clr; en = e;
    model_step();
    push_exp();
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected record per clock edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("code",      32'(d0_code),  32'(e.code));
        chk("xfer_cnt",  32'(d0_xfer),  32'(e.xfer));
        chk("stall_cnt", 32'(d0_stall), 32'(e.stall));
        chk("viol_drop", 32'(d0_vd),    32'(e.vd));
        chk("viol_chg",  32'(d0_vc),    32'(e.vc));
        chk("mutex_off", 32'(d0_mx),    32'd0);
        chk("mutex_on",  32'(d1_mx),    32'(e.mx));
        chk("d1_xfer",   32'(d1_xfer),  32'(e.xfer));
      end
    end
  end

  initial begin : stim
    logic [NC-1:0]    rv, rr;
    logic [NC*NB-1:0] rm;
    logic             rc, re;
    reset_n = 1'b0; clear = 1'b0; en = 1'b0;
    val = '0; rdy = '0; msg = '0;
    repeat (2) drive(1'b0, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
    repeat (2) drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);

    // Stall on ch1, then asynchronous reset mid-cycle with everything firing.
    drive(1'b1, 2'b11, 2'b11, 16'h3300, 1'b0, 1'b1);
    drive(1'b1, 2'b10, 2'b00, 16'h3300, 1'b0, 1'b1);
    drive(1'b0, 2'b11, 2'b11, 16'h0000, 1'b0, 1'b1);
    #2;
    chk("async_code",  32'(d0_code),  32'd0);
    chk("async_xfer",  32'(d0_xfer),  32'd0);
    chk("async_stall", 32'(d0_stall), 32'd0);
    chk("async_mutex", 32'(d1_mx),    32'd0);
    drive(1'b0, 2'b11, 2'b11, 16'h0000, 1'b0, 1'b1);
    repeat (3) drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
    post();
    chk("idle_code", 32'(d0_code), 32'd0);
    chk("idle_drop", 32'(d0_vd),   32'd0);

    // Trace codes: ch0 fire, ch1 stall.
    drive(1'b1, 2'b11, 2'b01, 16'h0000, 1'b0, 1'b1);
    post();
    chk("trace_code",  32'(d0_code),  32'hb);
    chk("trace_xfer",  32'(d0_xfer),  32'h01);
    chk("trace_stall", 32'(d0_stall), 32'h10);
    drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);

    // Saturation, then frozen counters with en=0.
    repeat (20) drive(1'b1, 2'b01, 2'b01, 16'h0000, 1'b0, 1'b1);
    post();
    chk("sat_xfer", 32'(d0_xfer), 32'h0f);
    repeat (5) drive(1'b1, 2'b01, 2'b00, 16'h0042, 1'b0, 1'b0);
    post();
    chk("frozen_code",  32'(d0_code[1:0]), 32'h2);
    chk("frozen_stall", 32'(d0_stall),     32'h00);
    drive(1'b1, 2'b01, 2'b01, 16'h0042, 1'b0, 1'b1);

    // Violations on ch1.
    drive(1'b1, 2'b10, 2'b00, 16'ha500, 1'b0, 1'b1);
    drive(1'b1, 2'b10, 2'b00, 16'h5a00, 1'b0, 1'b1);
    post();
    chk("chg_set", 32'(d0_vc), 32'h2);
    drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
    post();
    chk("drop_set", 32'(d0_vd), 32'h2);
    repeat (10) drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
    post();
    chk("drop_sticky", 32'(d0_vd), 32'h2);
    chk("chg_sticky",  32'(d0_vc), 32'h2);
    drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1);
    repeat (3) drive(1'b1, 2'b10, 2'b00, 16'ha500, 1'b0, 1'b1);
    drive(1'b1, 2'b10, 2'b10, 16'ha500, 1'b0, 1'b1);
    post();
    chk("clean_drop", 32'(d0_vd), 32'h0);
    chk("clean_chg",  32'(d0_vc), 32'h0);

    // Clear beats a same-cycle fire and violation; stall spans the clear.
    drive(1'b1, 2'b10, 2'b00, 16'h1100, 1'b0, 1'b1);
    drive(1'b1, 2'b11, 2'b01, 16'h2200, 1'b1, 1'b1);
    post();
    chk("clr_xfer",  32'(d0_xfer),  32'h0);
    chk("clr_stall", 32'(d0_stall), 32'h0);
    chk("clr_chg",   32'(d0_vc),    32'h0);
    drive(1'b1, 2'b00, 2'b00, 16'h0000, 1'b0, 1'b1);
    post();
    chk("span_drop", 32'(d0_vd), 32'h2);

    // Both channels fire together.
    drive(1'b1, 2'b11, 2'b11, 16'h0000, 1'b0, 1'b1);
    post();
    chk("mutex_on_set",  32'(d1_mx), 32'h1);
    chk("mutex_off_set", 32'(d0_mx), 32'h0);

    // Randomized traffic; pending channels usually hold val and msg steady.
    rm = '0;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (m_pend[c] && $urandom_range(0, 7) != 0) begin
          rv[c] = 1'b1;
        end else begin
          rv[c] = 1'($urandom_range(0, 1));
          rm[c*NB +: NB] = NB'($urandom_range(0, 3));
        end
        rr[c] = 1'($urandom_range(0, 1));
      end
      rc = ($urandom_range(0, 24) == 0);
      re = ($urandom_range(0, 3) != 0);
      drive(1'b1, rv, rr, rm, rc, re);
    end

    post();
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
